// File: rtl/uart_inst_loader.sv
// UART instruction loader: assembles little-endian 32-bit words from a
// received byte stream and writes them to consecutive instruction-memory
// words. Loading stops on a terminator word or when memory is full, at which
// point the CPU is released from reset.
module uart_inst_loader #(
  parameter int          ADDR_W       = 8,
  parameter logic [31:0] END_WORD     = 32'hFFFFFFFF,
  parameter int          BYTE_TIMEOUT = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_break,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              write_done,
  output logic              core_rst,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow,
  output logic              drop_err
);

  typedef enum logic {LOAD, DONE} state_t;

  // Idle counter only needs to reach BYTE_TIMEOUT-1 before it wraps to zero.
  localparam int              TO_W      = (BYTE_TIMEOUT < 2) ? 1 : $clog2(BYTE_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(BYTE_TIMEOUT - 1);
  localparam logic [ADDR_W:0] MEM_WORDS = {1'b1, {ADDR_W{1'b0}}};

  state_t          state;
  state_t          state_next;
  logic [1:0]      byte_idx;
  logic [23:0]     word_buf;   // lanes 0..2; lane 3 comes straight from rx_data
  logic [TO_W-1:0] idle_cnt;

  logic            word_done;
  logic [31:0]     word_asm;
  logic            is_end;
  logic            mem_full;
  logic            do_write;
  logic            do_overflow;

  // State register.
  // NOTE: every clocked assignment uses <= so all flops sample pre-edge values
  // regardless of statement order; = here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  // Next-state: LOAD exits only on terminator or a word that finds memory full.
  always_comb begin
    state_next = state;
    if (state == LOAD && word_done && (is_end || mem_full)) state_next = DONE;
  end

  // Per-cycle decode of the incoming byte against the partial word.
  // NOTE: each signal gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    word_done   = 1'b0;
    word_asm    = {rx_data, word_buf};
    is_end      = 1'b0;
    mem_full    = 1'b0;
    do_write    = 1'b0;
    do_overflow = 1'b0;
    if (state == LOAD && rx_valid && !rx_break && byte_idx == 2'd3) begin
      word_done   = 1'b1;
      is_end      = (word_asm == END_WORD);
      mem_full    = (word_count == MEM_WORDS);
      do_write    = !is_end && !mem_full;
      do_overflow = !is_end && mem_full;
    end
  end

  // Datapath: byte assembly, idle timeout, memory write port and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx   <= 2'd0;
      word_buf   <= 24'd0;
      idle_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      word_count <= '0;
      write_done <= 1'b0;
      overflow   <= 1'b0;
      drop_err   <= 1'b0;
      core_rst   <= 1'b1;
    end else begin
      imem_we    <= do_write;
      write_done <= (state_next == DONE);
      core_rst   <= (state_next == LOAD);

      if (do_write) begin
        imem_addr  <= word_count[ADDR_W-1:0];
        imem_wdata <= word_asm;
        word_count <= word_count + 1'b1;
      end
      if (do_overflow) overflow <= 1'b1;

      if (state == LOAD) begin
        if (rx_break) begin
          // BREAK wins over a same-cycle byte and abandons any partial word.
          if (byte_idx != 2'd0) drop_err <= 1'b1;
          byte_idx <= 2'd0;
          idle_cnt <= '0;
        end else if (rx_valid) begin
          case (byte_idx)
            2'd0:    word_buf[7:0]   <= rx_data;
            2'd1:    word_buf[15:8]  <= rx_data;
            2'd2:    word_buf[23:16] <= rx_data;
            default: ;
          endcase
          byte_idx <= byte_idx + 2'd1;
          idle_cnt <= '0;
        end else if (byte_idx != 2'd0) begin
          // Mid-word silence: give up after BYTE_TIMEOUT idle cycles.
          if (idle_cnt == TO_LAST) begin
            byte_idx <= 2'd0;
            idle_cnt <= '0;
            drop_err <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_inst_loader.sv
// Self-checking bench for uart_inst_loader: directed scenarios plus random
// byte/break/gap traffic, scored against a byte-queue model of the loader.
module tb_uart_inst_loader;

  localparam int          AW   = 2;
  localparam int          TO   = 20;
  localparam logic [31:0] ENDW = 32'hFFFFFFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_break = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          write_done;
  logic          core_rst;
  logic [AW:0]   word_count;
  logic          overflow;
  logic          drop_err;

  uart_inst_loader #(.ADDR_W(AW), .END_WORD(ENDW), .BYTE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_break(rx_break), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .write_done(write_done), .core_rst(core_rst),
    .word_count(word_count), .overflow(overflow), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];

  // Reference model state: bytes of the current partial word, and flags.
  logic [7:0]    m_part[$];
  int            m_count;
  int            m_idle;
  bit            m_done;
  bit            m_ovf;
  bit            m_drop;
  logic [AW-1:0] m_last_addr;
  logic [31:0]   m_last_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic void model_reset();
    m_part.delete();
    m_count     = 0;
    m_idle      = 0;
    m_done      = 1'b0;
    m_ovf       = 1'b0;
    m_drop      = 1'b0;
    m_last_addr = '0;
    m_last_data = 32'd0;
  endfunction

  // One clock cycle of loader behaviour, stated in terms of words and bytes.
  function automatic void model_step(input logic v, input logic b, input logic [7:0] d);
    logic [31:0] w;
    wr_t         e;
    if (m_done) return;
    if (b) begin
      if (m_part.size() != 0) m_drop = 1'b1;
      m_part.delete();
      m_idle = 0;
    end else if (v) begin
      m_part.push_back(d);
      m_idle = 0;
      if (m_part.size() == 4) begin
        w = {m_part[3], m_part[2], m_part[1], m_part[0]};
        m_part.delete();
        if (w == ENDW) begin
          m_done = 1'b1;
        end else if (m_count == (1 << AW)) begin
          m_ovf  = 1'b1;
          m_done = 1'b1;
        end else begin
          e.addr = AW'(m_count);
          e.data = w;
          exp_q.push_back(e);
          m_last_addr = e.addr;
          m_last_data = w;
          m_count++;
        end
      end
    end else if (m_part.size() != 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_drop = 1'b1;
        m_part.delete();
        m_idle = 0;
      end
    end
  endfunction

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_imem_we", 64'(imem_we), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("imem_addr", 64'(imem_addr), 64'(e.addr));
        check("imem_wdata", 64'(imem_wdata), 64'(e.data));
      end
    end
  end

  task automatic cycle(input logic v, input logic b, input logic [7:0] d);
    rx_valid = v;
    rx_break = b;
    rx_data  = d;
    @(posedge clk);
    #1;
    model_step(v, b, d);
    rx_valid = 1'b0;
    rx_break = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'd0);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, w[8*i +: 8]);
  endtask

  task automatic check_status(input string tag);
    check({tag, ".word_count"}, 64'(word_count), 64'(m_count));
    check({tag, ".write_done"}, 64'(write_done), 64'(m_done));
    check({tag, ".core_rst"},   64'(core_rst),   64'(!m_done));
    check({tag, ".overflow"},   64'(overflow),   64'(m_ovf));
    check({tag, ".drop_err"},   64'(drop_err),   64'(m_drop));
    check({tag, ".addr_hold"},  64'(imem_addr),  64'(m_last_addr));
    check({tag, ".wdata_hold"}, 64'(imem_wdata), 64'(m_last_data));
  endtask

  // Let any in-flight write drain, confirm nothing is still owed, then reset.
  task automatic do_reset(input string tag);
    cycle(1'b0, 1'b0, 8'd0);
    check({tag, ".pending_writes"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check({tag, ".rst_imem_we"}, 64'(imem_we), 64'(0));
    check_status({tag, ".rst"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r;
    model_reset();
    @(posedge clk);
    #1;

    // Single word, little-endian assembly.
    do_reset("w1");
    cycle(1'b1, 1'b0, 8'h23); cycle(1'b1, 1'b0, 8'h26);
    cycle(1'b1, 1'b0, 8'h81); cycle(1'b1, 1'b0, 8'h04);
    check_status("w1.after");
    idle(2);

    // Two words then terminator; later traffic is ignored.
    do_reset("term");
    send_word(32'h04812623);
    send_word(32'h05010413);
    send_word(ENDW);
    check_status("term.done");
    send_word(32'h12345678);
    cycle(1'b0, 1'b1, 8'd0);
    idle(3);
    check_status("term.hold");

    // Mid-word timeout of exactly BYTE_TIMEOUT idle cycles.
    do_reset("tmo");
    cycle(1'b1, 1'b0, 8'h13); cycle(1'b1, 1'b0, 8'h04);
    idle(TO);
    send_word(32'hFF700793);
    check_status("tmo.after");

    // One cycle short of the timeout keeps the partial word.
    do_reset("tmo_short");
    cycle(1'b1, 1'b0, 8'h11); cycle(1'b1, 1'b0, 8'h22);
    idle(TO - 1);
    cycle(1'b1, 1'b0, 8'h33); cycle(1'b1, 1'b0, 8'h44);
    check_status("tmo_short.after");

    // BREAK discards a partial word; BREAK beats a same-cycle byte.
    do_reset("brk");
    cycle(1'b1, 1'b0, 8'h01); cycle(1'b1, 1'b0, 8'h02);
    cycle(1'b0, 1'b1, 8'd0);
    send_word(32'hDDCCBBAA);
    cycle(1'b1, 1'b0, 8'h77);
    cycle(1'b1, 1'b1, 8'h55);
    send_word(32'h0A0B0C0D);
    check_status("brk.after");

    // Memory full: four writes, fifth word raises overflow, rest ignored.
    do_reset("ovf");
    for (int i = 0; i < 5; i++) send_word($urandom() & 32'h7FFFFFFF);
    check_status("ovf.done");
    send_word(32'h00000013);
    check_status("ovf.hold");

    // Reset mid-word restarts cleanly at address 0.
    do_reset("midrst");
    cycle(1'b1, 1'b0, 8'hAB); cycle(1'b1, 1'b0, 8'hCD); cycle(1'b1, 1'b0, 8'hEF);
    do_reset("midrst2");
    send_word(32'h00A00093);
    check_status("midrst.after");

    // Random traffic: bytes, breaks, and gaps around the timeout boundary.
    for (int seg = 0; seg < 20; seg++) begin
      do_reset("rnd");
      for (int c = 0; c < 60; c++) begin
        r = $urandom_range(0, 99);
        if (r < 3)       cycle(1'b0, 1'b1, 8'($urandom()));
        else if (r < 5)  cycle(1'b1, 1'b1, 8'($urandom()));
        else if (r < 60) cycle(1'b1, 1'b0, ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom()));
        else if (r < 96) cycle(1'b0, 1'b0, 8'd0);
        else             idle($urandom_range(TO - 2, TO + 1));
        if (c % 15 == 14) check_status("rnd");
      end
    end

    cycle(1'b0, 1'b0, 8'd0);
    check("final.pending_writes", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_inst_loader.md
UART_INST_LOADER -- requirements
Module: uart_inst_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width of the instruction memory (2^ADDR_W words).
REQ-002 SHALL have parameter END_WORD, default 32'hFFFFFFFF, the terminator word that ends loading.
REQ-003 SHALL have parameter BYTE_TIMEOUT, default 200000, the idle clk cycles allowed between bytes of one word.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port rx_valid, input, 1, one-cycle strobe marking rx_data as a received byte.
REQ-007 SHALL have port rx_data, input, 8, the received UART byte.
REQ-008 SHALL have port rx_break, input, 1, line BREAK detected.
REQ-009 SHALL have port imem_we, output, 1, instruction-memory write enable, one cycle per word.
REQ-010 SHALL have port imem_addr, output, ADDR_W, the word address for the write.
REQ-011 SHALL have port imem_wdata, output, 32, the assembled instruction word.
REQ-012 SHALL have port write_done, output, 1, a sticky flag marking loading complete.
REQ-013 SHALL have port core_rst, output, 1, which holds the CPU in reset while loading.
REQ-014 SHALL have port word_count, output, ADDR_W+1, the number of words written.
REQ-015 SHALL have port overflow, output, 1, sticky; set when a word arrives with memory full.
REQ-016 SHALL have port drop_err, output, 1, sticky; set when a partial word is discarded.

Function
REQ-017 SHALL have states LOAD and DONE; LOAD is the reset state, and DONE is left only via rst.
REQ-018 SHALL, in LOAD, capture rx_data on each rx_valid cycle into byte lane byte_idx; lane 0 is [7:0] and lane 3 is [31:24] (little-endian); byte_idx then increments modulo 4.
REQ-019 SHALL treat the word as complete on the cycle its 4th byte is captured (byte_idx==3 with rx_valid).
REQ-020 SHALL, for a complete word not equal to END_WORD with word_count < 2^ADDR_W, assert imem_we for exactly one cycle on the next cycle, with imem_wdata = the word and imem_addr = word_count[ADDR_W-1:0]; word_count increments in that same cycle.
REQ-021 SHALL, for a complete word equal to END_WORD, write nothing, and on the next cycle enter DONE with write_done=1 and core_rst=0.
REQ-022 SHALL, for a complete non-terminator word arriving when word_count == 2^ADDR_W, write nothing, set overflow=1, and enter DONE on the next cycle with write_done=1.
REQ-023 SHALL capture a byte that arrives in the same cycle imem_we is high normally, as lane 0 of the next word.
REQ-024 SHALL, on rx_break in LOAD, clear byte_idx and discard any partial word; drop_err is set only if byte_idx != 0; word_count is unaffected.
REQ-025 SHALL give rx_break priority over rx_valid when both are high in the same cycle: the byte is discarded.
REQ-026 SHALL count idle cycles while byte_idx != 0; when the count reaches BYTE_TIMEOUT, byte_idx clears, drop_err sets, and the counter resets; the counter clears on every captured byte.
REQ-027 SHALL ignore rx_valid and rx_break in DONE; imem_we stays 0 and all outputs hold.
REQ-028 SHALL drive core_rst = 1 in LOAD and 0 in DONE, registered, with no glitch.
REQ-029 SHALL keep imem_addr and imem_wdata stable while imem_we=0, holding their last-written values.

Reset
REQ-030 SHALL, while rst=1, force state=LOAD, byte_idx=0, the timeout counter=0, imem_we=0, imem_addr=0, imem_wdata=0, word_count=0, write_done=0, overflow=0, drop_err=0, core_rst=1.
REQ-031 SHALL, on rst mid-word or in DONE, discard all partial state on the next edge; loading then restarts at address 0.

Verification
REQ-032 SHALL be verified by: bytes 23,26,81,04 -> one imem_we pulse with addr 0, data 0x04812623; word_count=1.
REQ-033 SHALL be verified by: words 0x04812623, 0x05010413, then FF,FF,FF,FF -> writes at addr 0 and 1; write_done=1 and core_rst=0 one cycle after the last FF; no third write.
REQ-034 SHALL be verified by: bytes 13,04, then a BYTE_TIMEOUT idle gap, then 93,07,70,FF -> drop_err=1 and a write of 0xFF700793 at addr 0.
REQ-035 SHALL be verified by: 2 bytes, then rx_break, then 4 bytes AA,BB,CC,DD -> drop_err=1 and a write of 0xDDCCBBAA at addr 0.
REQ-036 SHALL be verified by: ADDR_W=2 with 5 non-terminator words -> 4 writes at addr 0..3, then overflow=1 and write_done=1 with no 5th write; later bytes are ignored.
REQ-037 SHALL be verified by: rst pulsed after 3 bytes of word 1, then a full word sent -> the write lands at addr 0 with the new data and drop_err=0.
